// File: rtl/reset_sequencer_pkg.sv
// Shared types and defaults for the staggered reset sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_NUM_DOMAINS = 4;
    localparam int DEF_STAGGER     = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Reset-release synchronizer: flop chain with D = 1, cleared asynchronously by i_rst_n.
// Latency: o_sync rises STAGES-1 edges after the first edge with i_rst_n high; assertion is immediate.
// Backpressure: none.
// Ports: i_clk clock, i_rst_n async active-low clear, o_sync synchronized release level.
module reset_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_sync
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign o_sync = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staggered per-domain reset generator: async assert, synchronized + held + staggered release.
// Latency: domain k releases SYNC_STAGES + HOLD_CYCLES + k*STAGGER edges after reset release.
// Backpressure: i_hold or i_sw_rst forces every domain back into reset; i_hold also parks the FSM in ASSERT.
// Ports: i_clk, i_rst_n (async active-low), i_sw_rst, i_hold; o_rst_n / o_rst per-domain resets
// (both polarities), o_done all released, o_state current FSM state.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int STAGGER     = DEF_STAGGER
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_sw_rst,
    input  logic                   i_hold,
    output logic [NUM_DOMAINS-1:0] o_rst_n,
    output logic [NUM_DOMAINS-1:0] o_rst,
    output logic                   o_done,
    output logic [1:0]             o_state
);

    localparam int LAST_REL = (NUM_DOMAINS - 1) * STAGGER;
    localparam int CNT_W    = $clog2(max_int(HOLD_CYCLES, LAST_REL) + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(LAST_REL);

    logic                   sync_rel;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_inc;
    logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_nxt;
    logic [NUM_DOMAINS-1:0] rst_q;
    logic                   done_q, done_nxt;
    logic                   abort;

    reset_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_sync  (sync_rel)
    );

    // Software reset is ignored while already in ASSERT; hold there only blocks the exit.
    assign abort   = (i_sw_rst | i_hold) & (state != ST_ASSERT);
    assign cnt_inc = cnt + CNT_W'(1);

    // State, counter and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_ASSERT;
            cnt     <= '0;
            rst_n_q <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rst_n_q <= rst_n_nxt;
            // Registered from the same next value so both polarities switch on the same edge.
            rst_q   <= ~rst_n_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state and counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_ASSERT: begin
                cnt_nxt = '0;
                if (sync_rel && !i_hold) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    // Counter restarts on the domain-0 release edge.
                    cnt_nxt   = '0;
                    state_nxt = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (abort) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                end else if (cnt_inc == REL_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    // Next values of the registered reset outputs.
    always_comb begin
        rst_n_nxt = rst_n_q;
        done_nxt  = done_q;
        case (state)
            ST_ASSERT: begin
                rst_n_nxt = '0;
                done_nxt  = 1'b0;
            end
            ST_HOLD: begin
                if (abort) begin
                    rst_n_nxt = '0;
                    done_nxt  = 1'b0;
                end else if (cnt == HOLD_LAST) begin
                    rst_n_nxt[0] = 1'b1;
                    done_nxt     = (NUM_DOMAINS == 1);
                end
            end
            ST_RELEASE: begin
                if (abort) begin
                    rst_n_nxt = '0;
                    done_nxt  = 1'b0;
                end else begin
                    // Domain k leaves reset on the edge where the count reaches k*STAGGER.
                    for (int k = 1; k < NUM_DOMAINS; k++) begin
                        if (cnt_inc == CNT_W'(k * STAGGER)) begin
                            rst_n_nxt[k] = 1'b1;
                        end
                    end
                    if (cnt_inc == REL_LAST) begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                rst_n_nxt = abort ? '0 : '1;
                done_nxt  = !abort;
            end
        endcase
    end

    assign o_rst_n = rst_n_q;
    assign o_rst   = rst_q;
    assign o_done  = done_q;
    assign o_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default configuration plus a one-domain, one-cycle-hold configuration
// sharing clock and stimulus, checked every cycle against a timeline model and at fixed edges
// against hand-computed values.
module tb_reset_sequencer;

    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_rst;
    logic       hold;

    logic [3:0] d_rst_n, d_rst;
    logic       d_done;
    logic [1:0] d_state;
    logic [0:0] s_rst_n, s_rst;
    logic       s_done;
    logic [1:0] s_state;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reset_sequencer u_dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sw_rst (sw_rst),
        .i_hold   (hold),
        .o_rst_n  (d_rst_n),
        .o_rst    (d_rst),
        .o_done   (d_done),
        .o_state  (d_state)
    );

    reset_sequencer #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (1),
        .NUM_DOMAINS (1),
        .STAGGER     (4)
    ) u_small (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sw_rst (sw_rst),
        .i_hold   (hold),
        .o_rst_n  (s_rst_n),
        .o_rst    (s_rst),
        .o_done   (s_done),
        .o_state  (s_state)
    );

    // ---------------- behavioural model ----------------
    // edges: number of rising edges since reset release (edge En makes it n+1).
    // asrt[i]: instance i is parked in reset; t[i]: edges since it left ASSERT.
    int unsigned edges;
    bit          asrt [2];
    int          t    [2];

    function automatic int p_n(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int p_h(input int i);
        return (i == 0) ? 16 : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges = 0;
            for (int i = 0; i < 2; i++) begin
                asrt[i] = 1'b1;
                t[i]    = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (asrt[i]) begin
                    // Synchronized release is visible from edge E2 on.
                    if (edges >= 2 && !hold) begin
                        asrt[i] = 1'b0;
                        t[i]    = 0;
                    end
                end else if (sw_rst || hold) begin
                    asrt[i] = 1'b1;
                end else if (t[i] < 1000000) begin
                    t[i] = t[i] + 1;
                end
            end
            edges = edges + 1;
        end
    end

    function automatic logic [3:0] exp_mask(input int i);
        logic [3:0] m;
        m = 4'h0;
        if (!asrt[i]) begin
            for (int k = 0; k < p_n(i); k++) begin
                if (t[i] >= p_h(i) + k * G) m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic exp_done(input int i);
        return !asrt[i] && (t[i] >= p_h(i) + (p_n(i) - 1) * G);
    endfunction

    function automatic logic [1:0] exp_state(input int i);
        if (asrt[i]) return 2'd0;
        if (t[i] < p_h(i)) return 2'd1;
        if (exp_done(i)) return 2'd3;
        return 2'd2;
    endfunction

    function automatic logic [3:0] exp_rst(input int i);
        logic [3:0] wm;
        wm = (p_n(i) == 4) ? 4'hF : 4'h1;
        return ~exp_mask(i) & wm;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (time %0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_dflt_rst_n", 32'(d_rst_n), 32'(exp_mask(0)));
        chk("cyc_dflt_rst",   32'(d_rst),   32'(exp_rst(0)));
        chk("cyc_dflt_done",  32'(d_done),  32'(exp_done(0)));
        chk("cyc_dflt_state", 32'(d_state), 32'(exp_state(0)));
        chk("cyc_small_rst_n", 32'(s_rst_n), 32'(exp_mask(1)));
        chk("cyc_small_rst",   32'(s_rst),   32'(exp_rst(1)));
        chk("cyc_small_done",  32'(s_done),  32'(exp_done(1)));
        chk("cyc_small_state", 32'(s_state), 32'(exp_state(1)));
    end

    // Return at the falling edge just after edge En of the current reset epoch.
    task automatic at_edge(input int n);
        for (int c = 0; c < 200 && edges < n + 1; c++) @(negedge clk);
        n_chk = n_chk + 1;
        if (edges != n + 1) begin
            n_fail = n_fail + 1;
            $display("FAIL at_edge_timeout: edge count %0d expected %0d", edges, n + 1);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_rst_n"}, 32'(d_rst_n), 32'h0);
        chk({nm, "_rst"},   32'(d_rst),   32'hF);
        chk({nm, "_done"},  32'(d_done),  32'h0);
        chk({nm, "_state"}, 32'(d_state), 32'h0);
        chk({nm, "_s_rst_n"}, 32'(s_rst_n), 32'h0);
        chk({nm, "_s_rst"},   32'(s_rst),   32'h1);
    endtask

    // Called just after a falling edge: drop reset mid-cycle, confirm outputs cleared
    // without any clock edge, release at the next falling edge (next rising edge is E0).
    task automatic async_pulse(input string nm);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals(nm);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        sw_rst = 1'b0;
        hold   = 1'b0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");

        // Power-on sequence with defaults.
        rst_n = 1'b1;
        at_edge(1);
        chk("por_e1_state", 32'(d_state), 32'd0);
        at_edge(2);
        chk("por_e2_state", 32'(d_state), 32'd1);
        chk("por_e2_s_state", 32'(s_state), 32'd1);
        at_edge(3);
        chk("small_e3_rst_n", 32'(s_rst_n), 32'd1);
        chk("small_e3_done",  32'(s_done),  32'd1);
        chk("small_e3_state", 32'(s_state), 32'd3);
        at_edge(17);
        chk("por_e17_rst_n", 32'(d_rst_n), 32'h0);
        at_edge(18);
        chk("por_e18_rst_n", 32'(d_rst_n), 32'h1);
        chk("model_e18_mask", 32'(exp_mask(0)), 32'h1);
        at_edge(22);
        chk("por_e22_rst_n", 32'(d_rst_n), 32'h3);
        at_edge(26);
        chk("por_e26_rst_n", 32'(d_rst_n), 32'h7);
        at_edge(29);
        chk("por_e29_done", 32'(d_done), 32'd0);
        at_edge(30);
        chk("por_e30_rst_n", 32'(d_rst_n), 32'hF);
        chk("por_e30_rst",   32'(d_rst),   32'h0);
        chk("por_e30_done",  32'(d_done),  32'd1);
        chk("model_e30_state", 32'(exp_state(0)), 32'd3);
        repeat (3) @(negedge clk);

        // Software reset pulse in RUN, sampled at edge T.
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        chk("sw_t_rst_n", 32'(d_rst_n), 32'h0);
        chk("sw_t_done",  32'(d_done),  32'd0);
        @(negedge clk);
        chk("sw_t1_state", 32'(d_state), 32'd1);
        repeat (15) @(negedge clk);
        chk("sw_t16_rst_n", 32'(d_rst_n), 32'h0);
        @(negedge clk);
        chk("sw_t17_rst_n", 32'(d_rst_n), 32'h1);

        // Async reset mid-RELEASE, then a full restart.
        async_pulse("async_run");
        at_edge(24);
        chk("mid_e24_rst_n", 32'(d_rst_n), 32'h3);
        async_pulse("async_mid");
        at_edge(18);
        chk("restart_e18_rst_n", 32'(d_rst_n), 32'h1);
        at_edge(30);
        chk("restart_e30_rst_n", 32'(d_rst_n), 32'hF);
        chk("restart_e30_done",  32'(d_done),  32'd1);

        // Hold from power-on through E40.
        hold = 1'b1;
        async_pulse("async_hold");
        at_edge(40);
        chk("hold_e40_state", 32'(d_state), 32'd0);
        hold = 1'b0;
        at_edge(41);
        chk("hold_e41_state", 32'(d_state), 32'd1);
        at_edge(56);
        chk("hold_e56_rst_n0", 32'(d_rst_n[0]), 32'd0);
        at_edge(57);
        chk("hold_e57_rst_n0", 32'(d_rst_n[0]), 32'd1);

        // Software reset on the edge scheduled for domain 2's release (E26).
        async_pulse("async_abort");
        at_edge(25);
        chk("abort_e25_rst_n", 32'(d_rst_n), 32'h3);
        sw_rst = 1'b1;
        at_edge(26);
        sw_rst = 1'b0;
        chk("abort_e26_rst_n2", 32'(d_rst_n[2]), 32'd0);
        chk("abort_e26_rst_n",  32'(d_rst_n),    32'h0);
        chk("abort_e26_state",  32'(d_state),    32'd0);
        at_edge(27);
        chk("abort_e27_state", 32'(d_state), 32'd1);

        // Randomized traffic checked by the per-cycle compare.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            sw_rst = ($urandom_range(0, 47) == 0);
            if (hold) hold = ($urandom_range(0, 3) != 0);
            else      hold = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 399) == 0) async_pulse("rand_async");
        end

        sw_rst = 1'b0;
        hold   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
